// File: rtl/alu_exec.sv
// alu_exec: execute stage; registered single-cycle ALU ops plus an iterative shift-add multiplier
//  clk, rst_n (async, active-low)
//  en_in, alu_op, alu_a, alu_b : operation request, accepted when en_in && !busy
//  alu_out, en_out             : registered result and its 1-cycle update strobe
//  busy                        : multiply in progress, new requests are dropped
//  flag_z/n/c/v                : zero, negative, carry/borrow, signed overflow
module alu_exec #(
  parameter int DWIDTH = 16,
  parameter int SHW = $clog2(DWIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  input  logic [3:0]        alu_op,
  input  logic [DWIDTH-1:0] alu_a,
  input  logic [DWIDTH-1:0] alu_b,
  output logic [DWIDTH-1:0] alu_out,
  output logic              en_out,
  output logic              busy,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [2*DWIDTH-1:0] mcand, acc, acc_n;
  logic [DWIDTH-1:0] mplier, res;
  logic [SHW-1:0] cnt, amt;
  logic [DWIDTH:0] sum, diff, shl_w, shr_w, sra_w;
  logic accept, is_mul, done, upd, wr, c, v;
  assign busy = (state == RUN);
  assign accept = en_in && (state == IDLE);
  assign is_mul = (alu_op == 4'd10);
  assign amt = alu_b[SHW-1:0];
  assign sum = {1'b0, alu_a} + {1'b0, alu_b};
  assign diff = {1'b0, alu_a} - {1'b0, alu_b};
  // one guard bit below/above the operand catches the last bit shifted out
  assign shl_w = {1'b0, alu_a} << amt;
  assign shr_w = {alu_a, 1'b0} >> amt;
  assign sra_w = $signed({alu_a, 1'b0}) >>> amt;
  assign acc_n = acc + (mplier[0] ? mcand : '0);
  assign done = (state == RUN) && (cnt == SHW'(DWIDTH - 1));
  assign upd = (accept && !is_mul) || done;
  always_comb begin
    state_n = state;
    if (state == IDLE && accept && is_mul) state_n = RUN;
    if (done) state_n = IDLE;
  end
  always_comb begin
    res = '0;
    c = 1'b0;
    v = 1'b0;
    wr = 1'b1;
    case (alu_op)
      4'd0: begin
        res = sum[DWIDTH-1:0];
        c = sum[DWIDTH];
        v = (alu_a[DWIDTH-1] == alu_b[DWIDTH-1]) && (sum[DWIDTH-1] != alu_a[DWIDTH-1]);
      end
      4'd1, 4'd9: begin
        res = diff[DWIDTH-1:0];
        c = diff[DWIDTH];
        v = (alu_a[DWIDTH-1] != alu_b[DWIDTH-1]) && (diff[DWIDTH-1] != alu_a[DWIDTH-1]);
        wr = (alu_op == 4'd1);
      end
      4'd2: res = alu_a & alu_b;
      4'd3: res = alu_a | alu_b;
      4'd4: res = alu_a ^ alu_b;
      4'd5: res = ~alu_a;
      4'd6: begin
        res = shl_w[DWIDTH-1:0];
        c = shl_w[DWIDTH];
      end
      4'd7: begin
        res = shr_w[DWIDTH:1];
        c = shr_w[0];
      end
      4'd8: begin
        res = sra_w[DWIDTH:1];
        c = sra_w[0];
      end
      4'd11: res = alu_b;
      default: res = '0;
    endcase
    if (state == RUN) begin
      res = acc_n[DWIDTH-1:0];
      c = |acc_n[2*DWIDTH-1:DWIDTH];
      v = c;
      wr = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out <= '0;
      en_out <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      en_out <= upd;
      if (accept && is_mul) begin
        mcand <= {{DWIDTH{1'b0}}, alu_a};
        mplier <= alu_b;
        acc <= '0;
        cnt <= '0;
      end
      if (state == RUN) begin
        acc <= acc_n;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
      end
      if (upd) begin
        if (wr) alu_out <= res;
        flag_z <= (res == '0);
        flag_n <= res[DWIDTH-1];
        flag_c <= c;
        flag_v <= v;
      end
    end
  end
endmodule
